// File: rtl/serial_mag_compare_pkg.sv
// serial_mag_compare_pkg: shared state encoding and result-select constants
package serial_mag_compare_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
    localparam logic SEL_LT = 1'b0;
    localparam logic SEL_GT = 1'b1;
endpackage

// File: rtl/serial_mag_compare_cmp_bit_cell.sv
// cmp_bit_cell: sticky one-bit compare step, the first differing bit (MSB first) decides
module cmp_bit_cell
    import serial_mag_compare_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic lt_in,
    input  logic gt_in,
    output wire  lt_out,
    output wire  gt_out
);
    wire a_n, b_n, lt_n, gt_n, lt_new, gt_new;
    not (a_n, a_bit);
    not (b_n, b_bit);
    not (lt_n, lt_in);
    not (gt_n, gt_in);
    and (lt_new, a_n, b_bit, lt_n, gt_n);
    and (gt_new, a_bit, b_n, lt_n, gt_n);
    or  (lt_out, lt_in, lt_new);
    or  (gt_out, gt_in, gt_new);
endmodule

// File: rtl/serial_mag_compare.sv
// serial_mag_compare: bit-serial MSB-first magnitude comparator with latched lt/gt select
module serial_mag_compare
    import serial_mag_compare_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sel,
    input  logic abort,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic result,
    output logic lt,
    output logic gt,
    output logic eq
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sel_q, lt_q, gt_q;
    logic             lt_nxt, gt_nxt;
    logic             accept, shift_en, last;

    cmp_bit_cell u_cell (
        .a_bit  (a_bit),
        .b_bit  (b_bit),
        .lt_in  (lt_q),
        .gt_in  (gt_q),
        .lt_out (lt_nxt),
        .gt_out (gt_nxt)
    );

    assign accept   = (state == ST_IDLE) && start;
    assign shift_en = (state == ST_SHIFT) && !abort && bit_valid;
    assign last     = shift_en && (cnt == '0);
    assign busy     = state != ST_IDLE;
    assign done     = state == ST_DONE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: DONE and aborted SHIFT both fall back to IDLE
    always_comb begin
        state_nxt = ST_IDLE;
        if (accept)                             state_nxt = ST_SHIFT;
        else if (state == ST_SHIFT && !abort)   state_nxt = last ? ST_DONE : ST_SHIFT;
    end

    // Bit counter, sticky decision and registered result captured on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sel_q  <= SEL_LT;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            result <= 1'b0;
        end else if (accept) begin
            cnt    <= CNT_W'(WIDTH - 1);
            sel_q  <= sel;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            result <= 1'b0;
        end else if (state == ST_SHIFT && abort) begin
            cnt  <= '0;
            lt_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (shift_en) begin
            cnt  <= last ? '0 : cnt - CNT_W'(1);
            lt_q <= lt_nxt;
            gt_q <= gt_nxt;
            if (last) begin
                lt     <= lt_nxt;
                gt     <= gt_nxt;
                eq     <= !lt_nxt && !gt_nxt;
                result <= (sel_q == SEL_GT) ? gt_nxt : lt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_mag_compare.sv
// tb_serial_mag_compare: directed checks on WIDTH=2, 8 and 4 instances sharing the serial inputs
module tb_serial_mag_compare;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic       sel = 1'b0, abort = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
    logic [2:0] busy_v, done_v, res_v, lt_v, gt_v, eq_v;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_mag_compare #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sel(sel), .abort(abort),
        .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit), .busy(busy_v[0]),
        .done(done_v[0]), .result(res_v[0]), .lt(lt_v[0]), .gt(gt_v[0]), .eq(eq_v[0])
    );
    serial_mag_compare #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sel(sel), .abort(abort),
        .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit), .busy(busy_v[1]),
        .done(done_v[1]), .result(res_v[1]), .lt(lt_v[1]), .gt(gt_v[1]), .eq(eq_v[1])
    );
    serial_mag_compare #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sel(sel), .abort(abort),
        .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit), .busy(busy_v[2]),
        .done(done_v[2]), .result(res_v[2]), .lt(lt_v[2]), .gt(gt_v[2]), .eq(eq_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One compare on instance d; exp = {lt,gt,eq,result}; optional stall, mid-run start poke, start in DONE
    task automatic run(input int d, input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input int stall_at, input int stall_n, input bit poke,
                       input bit dstart, input logic [3:0] exp, input int exp_lat, input string tag);
        int n = 0;
        @(negedge clk);
        start_v[d] = 1'b1;
        sel = s;
        for (int i = 0; i < w; i++) begin
            if (i == stall_at) repeat (stall_n) begin
                @(negedge clk);
                n++;
                start_v = '0;
                bit_valid = 1'b0;
            end
            @(negedge clk);
            n++;
            start_v = '0;
            bit_valid = 1'b1;
            a_bit = a[w-1-i];
            b_bit = b[w-1-i];
            if (poke && i == 1) begin
                start_v[d] = 1'b1;
                sel = ~s;
            end
        end
        @(negedge clk);
        n++;
        start_v = '0;
        bit_valid = 1'b0;
        while (!done_v[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_flags"}, {lt_v[d], gt_v[d], eq_v[d], res_v[d]}, exp);
        start_v[d] = dstart;
        @(negedge clk);
        start_v = '0;
        check({tag, "_pulse"}, done_v[d], 1'b0);
        check({tag, "_idle"}, busy_v[d], 1'b0);
        check({tag, "_hold"}, {lt_v[d], gt_v[d], eq_v[d], res_v[d]}, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        logic [3:0] e;
        repeat (2) @(negedge clk);
        check("reset_outs", {busy_v, done_v, res_v, lt_v, gt_v, eq_v}, 18'd0);
        rst_n = 1'b1;

        run(0, 2, 8'd2, 8'd1, 1'b0, -1, 0, 1'b0, 1'b0, 4'b0100, 3, "w2_2v1_lt");
        run(0, 2, 8'd2, 8'd1, 1'b1, -1, 0, 1'b0, 1'b0, 4'b0101, 3, "w2_2v1_gt");
        run(0, 2, 8'd3, 8'd3, 1'b0, -1, 0, 1'b0, 1'b0, 4'b0010, 3, "w2_3v3");
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int s = 0; s < 2; s++) begin
                    e = {a < b, a > b, a == b, (s == 1) ? (a > b) : (a < b)};
                    run(0, 2, 8'(a), 8'(b), 1'(s), -1, 0, 1'b0, 1'b0, e, 3,
                        $sformatf("w2_a%0d_b%0d_s%0d", a, b, s));
                end

        run(1, 8, 8'h80, 8'h7F, 1'b0, -1, 0, 1'b0, 1'b0, 4'b0100, 9, "w8_msb");
        run(2, 4, 8'hA, 8'hB, 1'b0, -1, 0, 1'b0, 1'b0, 4'b1001, 5, "w4_nostall");
        run(2, 4, 8'hA, 8'hB, 1'b0, 2, 3, 1'b0, 1'b0, 4'b1001, 8, "w4_stall");
        run(2, 4, 8'h5, 8'h9, 1'b0, -1, 0, 1'b1, 1'b0, 4'b1001, 5, "w4_poke");
        run(0, 2, 8'd1, 8'd0, 1'b1, -1, 0, 1'b0, 1'b1, 4'b0101, 3, "w2_start_in_done");

        @(negedge clk);
        start_v[2] = 1'b1;
        sel = 1'b0;
        @(negedge clk);
        start_v = '0;
        check("abort_accept_clear", {lt_v[2], gt_v[2], eq_v[2], res_v[2]}, 4'b0000);
        check("abort_busy", busy_v[2], 1'b1);
        bit_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        a_bit = 1'b0;
        b_bit = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", busy_v[2], 1'b0);
        seen = done_v[2];
        for (int i = 0; i < 6; i++) begin
            a_bit = i[0];
            b_bit = i[1];
            @(negedge clk);
            seen |= done_v[2];
        end
        bit_valid = 1'b0;
        check("abort_no_done", seen, 1'b0);
        run(2, 4, 8'h3, 8'h3, 1'b1, -1, 0, 1'b0, 1'b0, 4'b0010, 5, "post_abort");

        @(negedge clk);
        start_v[1] = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        start_v = '0;
        bit_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b0;
        @(negedge clk);
        a_bit = 1'b0;
        check("pre_reset_busy", busy_v[1], 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", {busy_v, done_v, res_v, lt_v, gt_v, eq_v}, 18'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bit_valid = 1'b0;
        run(1, 8, 8'h01, 8'h02, 1'b1, -1, 0, 1'b0, 1'b0, 4'b1000, 9, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
